// File: rtl/multiport_regfile.sv
// Register file with one byte-enabled write port, two read ports and a hardware clear sweep.
// Latency: reads return one cycle after acceptance; a write is visible to a same-cycle read.
// Backpressure: busy is high during the clear sweep, and writes, reads and CLR are ignored then.
module multiport_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  EN,
    input  logic                  WR,
    input  logic [ADDR_W-1:0]     sel_i1,
    input  logic [DATA_W-1:0]     Ip1,
    input  logic [DATA_W/8-1:0]   be,
    input  logic                  RD,
    input  logic [ADDR_W-1:0]     sel_o1,
    input  logic [ADDR_W-1:0]     sel_o2,
    output logic [DATA_W-1:0]     Op1,
    output logic [DATA_W-1:0]     Op2,
    output logic                  Op_valid,
    input  logic                  CLR,
    output logic                  busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   cnt;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                wr_acc;
    logic                rd_acc;
    logic                wr_ok;
    logic [DATA_W-1:0]   wr_merged;
    logic [DATA_W-1:0]   rd1_val;
    logic [DATA_W-1:0]   rd2_val;

    assign busy = (state == SWEEP);

    // A CLR request in IDLE takes priority over a simultaneous write or read.
    assign wr_acc = EN & WR & ~busy & ~CLR;
    assign rd_acc = EN & RD & ~busy & ~CLR;
    // With a hard-wired zero entry, writes to entry 0 are discarded.
    assign wr_ok  = wr_acc & ~((ZERO_REG != 0) && (sel_i1 == '0));

    // Byte-merge the incoming write data onto the current entry contents.
    always_comb begin
        wr_merged = mem[sel_i1];
        for (int k = 0; k < NB; k++) begin
            if (be[k]) begin
                wr_merged[8*k +: 8] = Ip1[8*k +: 8];
            end
        end
    end

    // Read data selection: write-first bypass, then zero-entry override.
    always_comb begin
        rd1_val = mem[sel_o1];
        rd2_val = mem[sel_o2];
        if (wr_ok && (sel_o1 == sel_i1)) begin
            rd1_val = wr_merged;
        end
        if (wr_ok && (sel_o2 == sel_i1)) begin
            rd2_val = wr_merged;
        end
        if ((ZERO_REG != 0) && (sel_o1 == '0)) begin
            rd1_val = '0;
        end
        if ((ZERO_REG != 0) && (sel_o2 == '0)) begin
            rd2_val = '0;
        end
    end

    // Clear FSM next state: start on CLR, finish after the last entry is swept.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (CLR) state_nx = SWEEP;
            SWEEP:   if (cnt == '1) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM state and sweep counter; the counter sits at 0 whenever idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state == SWEEP) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

    // Storage: the sweep zeroes one entry per cycle, otherwise accepted writes update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == SWEEP) begin
            mem[cnt] <= '0;
        end else if (wr_ok) begin
            mem[sel_i1] <= wr_merged;
        end
    end

    // Registered read ports; data holds when no read is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Op1      <= '0;
            Op2      <= '0;
            Op_valid <= 1'b0;
        end else begin
            Op_valid <= rd_acc;
            if (rd_acc) begin
                Op1 <= rd1_val;
                Op2 <= rd2_val;
            end
        end
    end

endmodule
